// File: rtl/cube_scan_driver.sv
// cube_scan_driver: display back-end for the 8x8x8 LED cube.
// Frames are captured into a shadow buffer. The shadow is copied into the active buffer only at
// the start of a scan (layer 0), so a frame is never shown half-old, half-new. Each layer's 64
// column bits are shifted MSB first into a 74HC595-style chain, latched, and then the matching
// one-hot layer drive is enabled.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   frame_cube_flat   512-bit frame; layer L occupies bits [L*64 +: 64]
//   frame_valid       1-cycle capture strobe for frame_cube_flat
//   ser_data/ser_clk  serial column data and shift clock (chain samples on rising ser_clk)
//   ser_latch         storage-register latch pulse
//   ser_oe_n          active-low chain output enable (1 = blank)
//   layer_sel         one-hot active-high layer drive
//   frame_swapped     1-cycle pulse in the first cycle that shows a newly swapped frame
module cube_scan_driver #(
  parameter int unsigned SCK_DIV    = 4,
  parameter int unsigned LAYER_HOLD = 2000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] frame_cube_flat,
  input  logic         frame_valid,
  output logic         ser_data,
  output logic         ser_clk,
  output logic         ser_latch,
  output logic         ser_oe_n,
  output logic [7:0]   layer_sel,
  output logic         frame_swapped
);

  // One counter covers a whole bit period (low half then high half) and the latch window.
  localparam int unsigned SubW  = $clog2(2 * SCK_DIV);
  localparam int unsigned HoldW = (LAYER_HOLD > 1) ? $clog2(LAYER_HOLD) : 1;

  localparam logic [SubW-1:0]  SubLast   = SubW'(2 * SCK_DIV - 1);
  localparam logic [SubW-1:0]  SubHigh   = SubW'(SCK_DIV);
  localparam logic [SubW-1:0]  LatchLast = SubW'(SCK_DIV - 1);
  localparam logic [HoldW-1:0] HoldLast  = HoldW'(LAYER_HOLD - 1);

  typedef enum logic [1:0] {StIdle, StShift, StLatch, StHold} state_e;

  state_e             state_q, state_d;
  logic [SubW-1:0]    sub_q, sub_d;
  logic [5:0]         bit_q, bit_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [2:0]         layer_q, layer_d;
  logic [511:0]       active_q, shadow_q;
  logic               pending_q;
  logic [7:0]         layer_sel_q;
  logic               lit_q;
  logic               swapped_q;
  logic               swap;
  logic               latch_done;

  always_comb begin
    state_d    = state_q;
    sub_d      = sub_q;
    bit_d      = bit_q;
    hold_d     = hold_q;
    layer_d    = layer_q;
    swap       = 1'b0;
    latch_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          state_d = StShift;
          swap    = 1'b1;
          sub_d   = '0;
          bit_d   = '0;
        end
      end
      StShift: begin
        if (sub_q == SubLast) begin
          sub_d = '0;
          bit_d = bit_q + 6'd1;
          if (bit_q == 6'd63) begin
            state_d = StLatch;
          end
        end else begin
          sub_d = sub_q + 1'b1;
        end
      end
      StLatch: begin
        if (sub_q == LatchLast) begin
          sub_d      = '0;
          hold_d     = '0;
          state_d    = StHold;
          latch_done = 1'b1;
        end else begin
          sub_d = sub_q + 1'b1;
        end
      end
      StHold: begin
        if (hold_q == HoldLast) begin
          layer_d = layer_q + 3'd1;
          state_d = StShift;
          sub_d   = '0;
          bit_d   = '0;
          // Only a wrap back to layer 0 may pick up a new frame.
          swap    = pending_q && (layer_q == 3'd7);
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sub_q       <= '0;
      bit_q       <= '0;
      hold_q      <= '0;
      layer_q     <= '0;
      active_q    <= '0;
      shadow_q    <= '0;
      pending_q   <= 1'b0;
      layer_sel_q <= '0;
      lit_q       <= 1'b0;
      swapped_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sub_q     <= sub_d;
      bit_q     <= bit_d;
      hold_q    <= hold_d;
      layer_q   <= layer_d;
      swapped_q <= swap;
      if (frame_valid) begin
        shadow_q <= frame_cube_flat;
      end
      // Swap copies the pre-edge shadow; a same-cycle strobe stays pending for the next scan.
      if (swap) begin
        active_q <= shadow_q;
      end
      pending_q <= frame_valid | (pending_q & ~swap);
      if (latch_done) begin
        layer_sel_q <= 8'd1 << layer_q;
        lit_q       <= 1'b1;
      end
    end
  end

  // {layer, ~bit} indexes W[63 - bit] of the current layer word.
  assign ser_data      = (state_q == StShift) ? active_q[{layer_q, ~bit_q}] : 1'b0;
  assign ser_clk       = (state_q == StShift) && (sub_q >= SubHigh);
  assign ser_latch     = (state_q == StLatch);
  // Blank until the first layer has been latched, and during every latch window.
  assign ser_oe_n      = ~lit_q | (state_q == StLatch);
  assign layer_sel     = layer_sel_q;
  assign frame_swapped = swapped_q;

endmodule

// File: tb/tb_cube_scan_driver.sv
module tb_cube_scan_driver;
  localparam int unsigned SD = 2;
  localparam int unsigned LH = 16;
  localparam int LP = 128 * SD + SD + LH;  // layer period
  localparam int SP = 8 * LP;              // scan period

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] frame_cube_flat = '0;
  logic         frame_valid = 1'b0;
  logic         ser_data, ser_clk, ser_latch, ser_oe_n, frame_swapped;
  logic [7:0]   layer_sel;

  cube_scan_driver #(.SCK_DIV(SD), .LAYER_HOLD(LH)) dut (
    .clk             (clk),
    .rst             (rst),
    .frame_cube_flat (frame_cube_flat),
    .frame_valid     (frame_valid),
    .ser_data        (ser_data),
    .ser_clk         (ser_clk),
    .ser_latch       (ser_latch),
    .ser_oe_n        (ser_oe_n),
    .layer_sel       (layer_sel),
    .frame_swapped   (frame_swapped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Edge counter since reset release plus a log of every captured frame.
  int           cyc = 0;
  int           log_edge[$];
  logic [511:0] log_data[$];

  initial forever begin
    @(posedge clk);
    if (rst) begin
      cyc = 0;
      log_edge.delete();
      log_data.delete();
    end else begin
      cyc++;
      if (frame_valid) begin
        log_edge.push_back(cyc);
        log_data.push_back(frame_cube_flat);
      end
    end
  end

  // Scan m starts one edge after the first capture, then every SP edges.
  function automatic int scan_edge(input int m);
    return log_edge[0] + 1 + m * SP;
  endfunction

  // A scan shows the newest frame captured strictly before its starting edge.
  function automatic logic [63:0] model_word(input int m, input int layer);
    logic [511:0] f;
    int e;
    f = '0;
    e = scan_edge(m);
    foreach (log_edge[i]) if (log_edge[i] < e) f = log_data[i];
    return f[layer*64 +: 64];
  endfunction

  // A scan swaps when some frame arrived since the previous scan start.
  function automatic int model_swaps(input int upto);
    int cnt;
    int lo;
    bit hit;
    cnt = 0;
    if (log_edge.size() == 0) return 0;
    for (int m = 0; scan_edge(m) <= upto; m++) begin
      lo  = (m == 0) ? 0 : scan_edge(m - 1);
      hit = 1'b0;
      foreach (log_edge[i]) if (log_edge[i] >= lo && log_edge[i] < scan_edge(m)) hit = 1'b1;
      if (hit) cnt++;
    end
    return cnt;
  endfunction

  // Protocol monitor: decodes the serial stream and checks each completed layer.
  int          mon_j = 0;
  int          mon_rises = 0;
  int          mon_oe_hi = 0;
  int          mon_sw = 0;
  int          mon_sw_hi = 0;
  logic [63:0] mon_bits = '0;
  logic        prev_clk = 1'b0, prev_latch = 1'b0, prev_sw = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      mon_j = 0; mon_rises = 0; mon_oe_hi = 0; mon_sw = 0; mon_sw_hi = 0;
      prev_clk = 1'b0; prev_latch = 1'b0; prev_sw = 1'b0;
    end else begin
      if (ser_clk && !prev_clk) begin
        mon_bits = {mon_bits[62:0], ser_data};
        mon_rises++;
      end
      if (ser_oe_n) mon_oe_hi++;
      if (frame_swapped) begin
        mon_sw_hi++;
        if (!prev_sw) begin
          mon_sw++;
          if (log_edge.size() == 0) check("swap_without_frame", 1, 0);
          else check("swap_at_scan_edge", (cyc - scan_edge(0)) % SP, 0);
        end
      end
      if (!ser_latch && prev_latch) begin
        if (log_edge.size() == 0) begin
          check("latch_without_frame", 1, 0);
        end else begin
          check("latch_edge", cyc, scan_edge(0) + 128 * SD + SD + mon_j * LP);
          check("bit_count", mon_rises, 64);
          check("layer_word", mon_bits, model_word(mon_j / 8, mon_j % 8));
          check("layer_sel", layer_sel, 8'd1 << (mon_j % 8));
          check("oe_on", ser_oe_n, 0);
          if (mon_j > 0) check("oe_blank_cycles", mon_oe_hi, SD);
        end
        mon_j++;
        mon_rises = 0;
        mon_oe_hi = 0;
      end
      prev_clk   = ser_clk;
      prev_latch = ser_latch;
      prev_sw    = frame_swapped;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [511:0] f);
    frame_cube_flat = f;
    frame_valid     = 1'b1;
    tick();
    frame_valid     = 1'b0;
  endtask

  task automatic wait_latches(input int n, input string tag);
    int target;
    int t;
    target = mon_j + n;
    t = 0;
    while (mon_j < target && t < (n + 1) * LP + SP) begin
      tick();
      t++;
    end
    check(tag, mon_j >= target, 1);
  endtask

  // layer < 0 means any layer.
  task automatic wait_shift(input int layer, input int rises, input string tag);
    int t;
    t = 0;
    while (!((layer < 0 || mon_j % 8 == layer) && mon_rises >= rises) && t < 2 * SP) begin
      tick();
      t++;
    end
    check(tag, (layer < 0 || mon_j % 8 == layer) && mon_rises >= rises, 1);
  endtask

  task automatic idle_check(input int n, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ser_clk || ser_latch || !ser_oe_n || layer_sel != 8'd0 || frame_swapped || ser_data)
        bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_clk"}, ser_clk, 0);
    check({tag, "_latch"}, ser_latch, 0);
    check({tag, "_oe_n"}, ser_oe_n, 1);
    check({tag, "_layer_sel"}, layer_sel, 0);
    check({tag, "_swapped"}, frame_swapped, 0);
    check({tag, "_data"}, ser_data, 0);
  endtask

  function automatic logic [511:0] rand_frame();
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  logic [511:0] fa, fb, fc1, fc2, fd, fe;
  int sw_before;
  int e_next;

  initial begin
    // Reset and idle with no frames.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    reset_outputs("reset");
    idle_check(2000, "idle_quiet");

    // Single frame with only byte 0 set.
    fa = '0;
    fa[7:0] = 8'hFF;
    strobe(fa);
    wait_latches(1, "t2_first_latch");
    check("t2_word", mon_bits, 64'h0000_0000_0000_00FF);
    check("t2_swaps", mon_sw, 1);

    // Free-run over the static frame.
    wait_latches(15, "t3_free_run");
    check("t3_swaps", mon_sw, 1);
    check("t3_swap_width", mon_sw_hi, mon_sw);

    // New frame during layer 3: rest of the scan still shows the old one.
    fb = rand_frame();
    wait_shift(3, 10, "t4_wait_layer3");
    strobe(fb);
    wait_latches(6, "t4_to_layer0");
    check("t4_l0_word", mon_bits, fb[63:0]);
    check("t4_swaps", mon_sw, model_swaps(cyc));

    // Two frames within a scan, third lands on the swap edge itself.
    sw_before = mon_sw;
    fc1 = rand_frame();
    fc2 = rand_frame();
    fd  = rand_frame();
    wait_shift(1, 5, "t5_wait_layer1");
    strobe(fc1);
    wait_shift(4, 5, "t5_wait_layer4");
    strobe(fc2);
    e_next = scan_edge((cyc - scan_edge(0)) / SP + 1);
    while (cyc < e_next - 1) tick();
    strobe(fd);
    wait_latches(1, "t5_layer0_a");
    check("t5_l0_latest", mon_bits, fc2[63:0]);
    wait_latches(8, "t5_layer0_b");
    check("t5_l0_pending", mon_bits, fd[63:0]);
    check("t5_swaps_delta", mon_sw - sw_before, 2);
    check("t5_swaps", mon_sw, model_swaps(cyc));
    check("t5_swap_width", mon_sw_hi, mon_sw);

    // Reset in the middle of a shift; nothing swaps until a new frame.
    wait_shift(-1, 30, "t6_wait_bit30");
    rst = 1'b1;
    tick();
    reset_outputs("t6_reset");
    rst = 1'b0;
    idle_check(600, "t6_idle_quiet");
    check("t6_no_swap", mon_sw, 0);
    fe = rand_frame();
    strobe(fe);
    wait_latches(9, "t6_restart");
    check("t6_l0_word", mon_bits, fe[63:0]);
    check("t6_swaps", mon_sw, model_swaps(cyc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
